set_scan_ctrl: RTL

Sequencer for the set-coverage logic unit. Latches three circle descriptors (centre, radius) and a mode, then walks the 8x8 lattice (x, y in 1..8) one point per cycle. For each point it drives the 3-bit covered vector and the buffered mode to the logic unit, and counts the points for which the unit returns hit. Sits between the host command interface and the logic unit, which is instantiated alongside it.

---
 rtl/set_scan_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/set_scan_ctrl.sv
// set_scan_ctrl: latches three circles and a mode, walks the GRID_N^2 lattice
// and counts logic-unit hits. Optional `HIT_PIPE_EN registers hit_i first.
`ifndef MODE_SZ
`define MODE_SZ 2
`endif
`ifndef COVERED_SZ
`define COVERED_SZ 3
`endif
`ifndef MODE1
`define MODE1 2'd0
`define MODE2 2'd1
`define MODE3 2'd2
`define MODE4 2'd3
`endif

module set_scan_ctrl #(
  parameter int GRID_N  = 8,
  parameter int COORD_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [6*COORD_W-1:0]   central_i,
  input  logic [3*COORD_W-1:0]   radius_i,
  input  logic [`MODE_SZ-1:0]    mode_i,
  output logic [`COVERED_SZ-1:0] covered_o,
  output logic [`MODE_SZ-1:0]    mode_buf_o,
  input  logic                   hit_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [CNT_W-1:0]       candidate_o
);

  localparam int PW = $clog2(GRID_N + 1);
  localparam int DW = 2 * COORD_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [6*COORD_W-1:0]   cen_q;
  logic [3*COORD_W-1:0]   rad_q;
  logic [PW-1:0]          x_q, y_q;
  logic                   pt_vld_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [PW-1:0]          px, py;
  logic                   issue;
  logic                   use_in;
  logic                   last_pt;
  logic                   scan_end;
  logic                   acc;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [6*COORD_W-1:0]   cen_s;
  logic [3*COORD_W-1:0]   rad_s;
  logic [`COVERED_SZ-1:0] cov_d;
  logic                   start;

  function automatic logic in_circ(
    input logic [COORD_W-1:0] px_a,
    input logic [COORD_W-1:0] py_a,
    input logic [COORD_W-1:0] cx,
    input logic [COORD_W-1:0] cy,
    input logic [COORD_W-1:0] r
  );
    logic signed [COORD_W:0] dx, dy;
    logic [COORD_W:0]        ax, ay;
    logic [DW-1:0]           d2, r2;
    dx = $signed({1'b0, px_a}) - $signed({1'b0, cx});
    dy = $signed({1'b0, py_a}) - $signed({1'b0, cy});
    ax = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
    ay = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
    d2 = DW'(ax) * DW'(ax) + DW'(ay) * DW'(ay);
    r2 = DW'(r) * DW'(r);
    return d2 <= r2;
  endfunction

  assign start   = (state_q == IDLE) && en_i;
  assign last_pt = pt_vld_q &&
                   (x_q == PW'(GRID_N)) &&
                   (y_q == PW'(GRID_N));

`ifdef HIT_PIPE_EN
  logic vld_q, hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      hit_q <= 1'b0;
    end else begin
      vld_q <= pt_vld_q;
      hit_q <= hit_i;
    end
  end

  assign acc      = vld_q && hit_q;
  // last point has left the pipe once nothing new is issued
  assign scan_end = !pt_vld_q;
`else
  assign acc      = pt_vld_q && hit_i;
  assign scan_end = last_pt;
`endif

  assign cnt_nxt = cnt_q + CNT_W'(acc);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    use_in  = 1'b0;
    px      = PW'(1);
    py      = PW'(1);
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = SCAN;
          issue   = 1'b1;
          use_in  = 1'b1;
        end
      end
      SCAN: begin
        if (pt_vld_q && !last_pt) begin
          issue = 1'b1;
          if (x_q == PW'(GRID_N)) begin
            px = PW'(1);
            py = y_q + PW'(1);
          end else begin
            px = x_q + PW'(1);
            py = y_q;
          end
        end
        if (scan_end) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // the first point is evaluated straight from the ports
  assign cen_s = use_in ? central_i : cen_q;
  assign rad_s = use_in ? radius_i : rad_q;

  always_comb begin
    cov_d = '0;
    for (int k = 0; k < 3; k++) begin
      cov_d[2-k] = in_circ(
        COORD_W'(px),
        COORD_W'(py),
        cen_s[(6-2*k)*COORD_W-1 -: COORD_W],
        cen_s[(5-2*k)*COORD_W-1 -: COORD_W],
        rad_s[(3-k)*COORD_W-1 -: COORD_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cen_q       <= '0;
      rad_q       <= '0;
      mode_buf_o  <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pt_vld_q    <= 1'b0;
      covered_o   <= '0;
      cnt_q       <= '0;
      candidate_o <= '0;
    end else begin
      state_q  <= state_d;
      pt_vld_q <= issue;
      covered_o <= issue ? cov_d : '0;
      if (issue) begin
        x_q <= px;
        y_q <= py;
      end
      if (start) begin
        cen_q      <= central_i;
        rad_q      <= radius_i;
        mode_buf_o <= mode_i;
        cnt_q      <= '0;
      end else begin
        cnt_q <= cnt_nxt;
      end
      if (state_q == SCAN && scan_end)
        candidate_o <= cnt_nxt;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign valid_o = (state_q == DONE);

endmodule
